// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: Moore decode of state, with mem_ready/zero gated strobes.
// Memory states stall on mem_ready; a sticky mem_timeout flags long waits. MCCTRL_ADDI_EN builds addi support.
module mips_multicycle_control #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [1:0] alu_op,
  output logic [3:0] state,
  output logic       illegal_op,
  output logic       mem_timeout
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEX   = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [7:0] TO_LIM  = 8'(TIMEOUT_CYCLES);

  state_t     st;
  logic [7:0] wait_cnt;
  logic       waiting;
  logic       mw_d, irw_d, rw_d, pe_d, ill_d;

  assign state   = st;
  assign waiting = ((st == FETCH) || (st == MEMREAD) || (st == MEMWRITE)) && !mem_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st          <= FETCH;
      wait_cnt    <= 8'd0;
      mem_timeout <= 1'b0;
    end else begin
      // counter saturates at the limit so the flag cannot be missed on wrap
      if (waiting) begin
        if (wait_cnt < TO_LIM) wait_cnt <= wait_cnt + 8'd1;
        if (wait_cnt + 8'd1 >= TO_LIM) mem_timeout <= 1'b1;
      end else begin
        wait_cnt <= 8'd0;
      end

      case (st)
        FETCH:    if (mem_ready) st <= DECODE;
        DECODE: begin
          case (opcode)
            OP_LW, OP_SW: st <= MEMADR;
            OP_RTYP:      st <= EXECUTE;
            OP_BEQ:       st <= BRANCH;
`ifdef MCCTRL_ADDI_EN
            OP_ADDI:      st <= ADDIEX;
`endif
            OP_J:         st <= JUMP;
            default:      st <= FETCH;
          endcase
        end
        MEMADR:   st <= (opcode == OP_SW) ? MEMWRITE : MEMREAD;
        MEMREAD:  if (mem_ready) st <= MEMWB;
        MEMWB:    st <= FETCH;
        MEMWRITE: if (mem_ready) st <= FETCH;
        EXECUTE:  st <= ALUWB;
        ALUWB:    st <= FETCH;
        BRANCH:   st <= FETCH;
`ifdef MCCTRL_ADDI_EN
        ADDIEX:   st <= ADDIWB;
        ADDIWB:   st <= FETCH;
`endif
        JUMP:     st <= FETCH;
        default:  st <= FETCH;
      endcase
    end
  end

  always_comb begin
    mw_d       = 1'b0;
    irw_d      = 1'b0;
    rw_d       = 1'b0;
    pe_d       = 1'b0;
    ill_d      = 1'b0;
    iord       = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    alu_op     = 2'b00;
    case (st)
      FETCH: begin
        alu_src_b = 2'b01;
        irw_d     = mem_ready;
        pe_d      = mem_ready;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW, OP_RTYP, OP_BEQ, OP_J: ill_d = 1'b0;
`ifdef MCCTRL_ADDI_EN
          OP_ADDI: ill_d = 1'b0;
`endif
          default: ill_d = 1'b1;
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMREAD:  iord = 1'b1;
      MEMWB: begin
        mem_to_reg = 1'b1;
        rw_d       = 1'b1;
      end
      MEMWRITE: begin
        iord = 1'b1;
        mw_d = 1'b1;
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      ALUWB: begin
        reg_dst = 1'b1;
        rw_d    = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        pe_d      = zero;
      end
`ifdef MCCTRL_ADDI_EN
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      ADDIWB:   rw_d = 1'b1;
`endif
      JUMP: begin
        pc_src = 2'b10;
        pe_d   = 1'b1;
      end
      default: ;
    endcase
  end

  // strobes are killed combinationally so nothing fires once reset asserts
  assign mem_write  = mw_d  & ~reset;
  assign ir_write   = irw_d & ~reset;
  assign reg_write  = rw_d  & ~reset;
  assign pc_en      = pe_d  & ~reset;
  assign illegal_op = ill_d & ~reset;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Random instruction streams with random memory stalls, checked per cycle against an
// instruction-level path model plus a per-state output table and a wait-cycle timeout model.
module tb_mips_multicycle_control;
  localparam int TO = 4;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       mem_write, ir_write, reg_write, pc_en, iord, mem_to_reg, reg_dst, alu_src_a;
  logic [1:0] alu_src_b, pc_src, alu_op;
  logic [3:0] state;
  logic       illegal_op, mem_timeout;

  int checks = 0;
  int errors = 0;
  int consec = 0;
  bit exp_to = 1'b0;

  mips_multicycle_control #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write), .pc_en(pc_en),
    .iord(iord), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_op(alu_op), .state(state),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  logic [14:0] got_out;
  assign got_out = {mem_write, ir_write, reg_write, pc_en, iord, mem_to_reg, reg_dst,
                    alu_src_a, alu_src_b, pc_src, alu_op, illegal_op};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    if (op == LW || op == SW || op == RT || op == BEQ || op == JMP) return 1'b1;
`ifdef MCCTRL_ADDI_EN
    if (op == ADDI) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [14:0] exp_out(input int s, input bit mr, input bit z, input logic [5:0] op);
    bit mw = 0, irw = 0, rw = 0, pe = 0, io = 0, m2r = 0, rd = 0, sa = 0, ill = 0;
    logic [1:0] sb = 2'b00, ps = 2'b00, ao = 2'b00;
    case (s)
      0:  begin sb = 2'b01; irw = mr; pe = mr; end
      1:  begin sb = 2'b11; ill = !is_legal(op); end
      2:  begin sa = 1; sb = 2'b10; end
      3:  io = 1;
      4:  begin m2r = 1; rw = 1; end
      5:  begin io = 1; mw = 1; end
      6:  begin sa = 1; ao = 2'b10; end
      7:  begin rd = 1; rw = 1; end
      8:  begin sa = 1; ao = 2'b01; ps = 2'b01; pe = z; end
      9:  begin sa = 1; sb = 2'b10; end
      10: rw = 1;
      11: begin ps = 2'b10; pe = 1; end
      default: ;
    endcase
    return {mw, irw, rw, pe, io, m2r, rd, sa, sb, ps, ao, ill};
  endfunction

  // one cycle: called just after a negedge, returns just after the next negedge
  task automatic cyc(input int s, input bit mr, input bit z, input logic [5:0] op);
    opcode = op; zero = z; mem_ready = mr;
    #1;
    check("state", 32'(state), 32'(s));
    check("outputs", 32'(got_out), 32'(exp_out(s, mr, z, op)));
    check("mem_timeout", 32'(mem_timeout), 32'(exp_to));
    @(posedge clk);
    if ((s == 0 || s == 3 || s == 5) && !mr) begin
      consec++;
      if (consec >= TO) exp_to = 1'b1;
    end else begin
      consec = 0;
    end
    @(negedge clk);
  endtask

  task automatic visit(input int s, input int waits, input logic [5:0] op);
    if (s == 0 || s == 3 || s == 5) begin
      for (int i = 0; i < waits; i++) cyc(s, 1'b0, bit'($urandom_range(0, 1)), op);
      cyc(s, 1'b1, bit'($urandom_range(0, 1)), op);
    end else begin
      cyc(s, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), op);
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input int maxw);
    visit(0, $urandom_range(0, maxw), op);
    visit(1, 0, op);
    if (!is_legal(op)) return;
    case (op)
      LW:   begin visit(2, 0, op); visit(3, $urandom_range(0, maxw), op); visit(4, 0, op); end
      SW:   begin visit(2, 0, op); visit(5, $urandom_range(0, maxw), op); end
      RT:   begin visit(6, 0, op); visit(7, 0, op); end
      BEQ:  visit(8, 0, op);
      ADDI: begin visit(9, 0, op); visit(10, 0, op); end
      default: visit(11, 0, op);
    endcase
  endtask

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 6))
      0: return LW;
      1: return SW;
      2: return RT;
      3: return BEQ;
      4: return ADDI;
      5: return JMP;
      default: return 6'($urandom_range(0, 63));
    endcase
  endfunction

  task automatic do_reset();
    reset = 1'b1; mem_ready = 1'b1;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_outputs", 32'(got_out), 32'(exp_out(0, 1'b0, 1'b0, opcode)));
    check("rst_mem_timeout", 32'(mem_timeout), 32'd0);
    @(negedge clk);
    reset = 1'b0; consec = 0; exp_to = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // directed: R-type, lw with 3 stall cycles, beq both ways, illegal opcode
    run_instr(RT, 0);
    visit(0, 0, LW); visit(1, 0, LW); visit(2, 0, LW); visit(3, 3, LW); visit(4, 0, LW);
    visit(0, 0, BEQ); visit(1, 0, BEQ); cyc(8, 1'b0, 1'b1, BEQ);
    visit(0, 0, BEQ); visit(1, 0, BEQ); cyc(8, 1'b0, 1'b0, BEQ);
    run_instr(6'b111111, 0);
    run_instr(ADDI, 0);

    for (int n = 0; n < 200; n++) run_instr(pick_op(), 2);

    // timeout in FETCH: six stalls, then the flag must persist
    visit(0, 6, RT); visit(1, 0, RT); visit(6, 0, RT); visit(7, 0, RT);
    check("timeout_sticky", 32'(mem_timeout), 32'd1);
    for (int n = 0; n < 100; n++) run_instr(pick_op(), 6);
    do_reset();

    // async reset in the middle of a stalled store
    visit(0, 0, SW); visit(1, 0, SW); visit(2, 0, SW);
    for (int i = 0; i < 5; i++) cyc(5, 1'b0, 1'b0, SW);
    #1;
    check("mw_before_reset", 32'(mem_write), 32'd1);
    check("to_before_reset", 32'(mem_timeout), 32'd1);
    reset = 1'b1;
    #1;
    check("mw_async_drop", 32'(mem_write), 32'd0);
    check("state_async", 32'(state), 32'd0);
    check("to_async_clear", 32'(mem_timeout), 32'd0);
    mem_ready = 1'b1;
    #1;
    check("irw_in_reset", 32'(ir_write), 32'd0);
    check("pcen_in_reset", 32'(pc_en), 32'd0);
    @(negedge clk);
    reset = 1'b0; consec = 0; exp_to = 1'b0;
    for (int n = 0; n < 20; n++) run_instr(pick_op(), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Decodes the 6-bit opcode over several cycles and drives all datapath strobes and mux selects.
- Produces the 2-bit ALUOp consumed directly by the ALU control decoder: 00 = add, 01 = subtract, 10 = use funct.
- Stalls on a memory-ready handshake and flags memory timeouts.

Parameters:
- TIMEOUT_CYCLES, 16: consecutive wait cycles in a memory state before mem_timeout is set. Legal range 1..255.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- opcode  input  6  instruction[31:26] from the instruction register
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes the current access this cycle
- mem_write  output  1  memory write strobe
- ir_write  output  1  instruction register load
- reg_write  output  1  register file write
- pc_en  output  1  PC load enable
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- mem_to_reg  output  1  write-back select: 1 = MDR
- reg_dst  output  1  destination select: 1 = rd
- alu_src_a  output  1  ALU A select: 0 = PC, 1 = reg A
- alu_src_b  output  2  ALU B select: 00 = reg B, 01 = const 4, 10 = signext imm, 11 = signext imm << 2
- pc_src  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alu_op  output  2  to the ALU control decoder
- state  output  4  current state encoding (debug/verification)
- illegal_op  output  1  one-cycle pulse, unsupported opcode decoded
- mem_timeout  output  1  sticky memory-timeout flag

Behaviour:
- State encoding (fixed): FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12-15 are unreachable and recover to FETCH on the next clock.
- Reset (async, active-high):
  - state=FETCH, timeout counter=0, mem_timeout=0.
  - While reset is high, all strobes (mem_write, ir_write, reg_write, pc_en, illegal_op) are forced to 0.
  - Mux outputs take FETCH values: iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00, mem_to_reg=0, reg_dst=0.
  - Reset mid-instruction aborts the instruction; no strobe fires after reset asserts.
- Outputs: Moore decode of state, except that mem_ready gating and pc_en are combinational.
- Signals not listed for a state are 0.
- FETCH: iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. ir_write=pc_en=mem_ready. Stay while !mem_ready; else go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (precomputes branch target). Transitions by opcode:
  - 100011 (lw) / 101011 (sw) -> MEMADR
  - 000000 (R-type) -> EXECUTE
  - 000100 (beq) -> BRANCH
  - 001000 (addi) -> ADDIEX
  - 000010 (j) -> JUMP
  - any other opcode: illegal_op=1 for this cycle, then FETCH
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state: MEMREAD for lw, MEMWRITE for sw. The opcode is held stable by the IR.
- MEMREAD: iord=1. Stay while !mem_ready; else go to MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1 -> FETCH.
- MEMWRITE: iord=1, mem_write=1 held for every wait cycle. Stay while !mem_ready; else go to FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10 -> ALUWB.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero -> FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1 -> FETCH.
- JUMP: pc_src=10, pc_en=1 -> FETCH.
- Instruction latency with mem_ready always 1:
  - lw: 5 cycles
  - sw, R-type, addi: 4 cycles
  - beq, j: 3 cycles
- Timeout:
  - An 8-bit counter increments each cycle spent in FETCH, MEMREAD or MEMWRITE with mem_ready=0. It clears when mem_ready=1 or on leaving the state.
  - When the counter reaches TIMEOUT_CYCLES, mem_timeout is set. The counter saturates.
  - The FSM keeps waiting; no abort.
  - mem_timeout is cleared only by reset.
- mem_ready=1 in a state that does not wait on memory is ignored.

Optional Feature:
- Macro: MCCTRL_ADDI_EN.
- Defined: addi is supported via ADDIEX/ADDIWB as described above.
- Not defined: ADDIEX/ADDIWB are not built; state codes 9 and 10 behave as unreachable codes. Opcode 001000 is treated as illegal: illegal_op pulses in DECODE, then FETCH.

Test Plan:
- Reset released, mem_ready=1, opcode=000000, zero=0 -> state sequence 0,1,6,7,0. alu_op=10 in EXECUTE; reg_write=1 and reg_dst=1 only in ALUWB.
- opcode=100011, mem_ready low for 3 cycles in MEMREAD -> state holds 3 for 4 cycles, then 4. mem_to_reg=1 and reg_write=1 for exactly 1 cycle.
- opcode=000100, zero=1 then repeated with zero=0 -> pc_en=1 with pc_src=01 and alu_op=01 in BRANCH for the first run; pc_en=0 for the second.
- opcode=111111 -> illegal_op=1 for the DECODE cycle only, next state FETCH, no reg_write or mem_write.
- TIMEOUT_CYCLES=4, mem_ready=0 in FETCH for 6 cycles -> mem_timeout rises after the 4th wait cycle and stays 1 after mem_ready returns; cleared only by reset.
- Reset asserted mid-MEMWRITE with mem_write=1 -> mem_write drops immediately (async), state=0, mem_timeout=0.
